// File: rtl/cpu10_pkg.sv
// Shared types and constants for the 10-bit CPU.
// Fetch options: IFETCH_JUMP_PREDECODE_EN.
package cpu10_pkg;

  localparam int INSTR_W = 10;
  localparam int ADDR_W  = 10;

  localparam logic [INSTR_W-1:0] HALT_WORD = 10'b0010000010;
  localparam logic [3:0]         OP_JUMP   = 4'b1000;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_HALT
  } state_t;

  function automatic logic is_jump(
    input logic [INSTR_W-1:0] w
  );
    return w[9:6] == OP_JUMP;
  endfunction

  function automatic logic [ADDR_W-1:0] jump_target(
    input logic [INSTR_W-1:0] w
  );
    return {4'b0000, w[5:0]};
  endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// Next-PC selection for the fetch unit.
// IFETCH_JUMP_PREDECODE_EN enables jump predecode.
module ifetch_next_pc
  import cpu10_pkg::*;
(
  input  logic               reset,
  input  state_t             state,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               fetch_en,
  output logic               halt_hit,
  output logic               jump_hit,
  output logic [ADDR_W-1:0]  next_pc
);

  logic run;
  logic sel_rst;
  logic sel_init;
  logic sel_redir;
  logic sel_jump;
  logic sel_inc;

  assign run      = state == ST_RUN;
  assign fetch_en = run & ~stall & ~redirect_valid;
  assign halt_hit = fetch_en & (imem_rdata == HALT_WORD);

`ifdef IFETCH_JUMP_PREDECODE_EN
  assign jump_hit = fetch_en & is_jump(imem_rdata);
`else
  assign jump_hit = 1'b0;
`endif

  // Mutually exclusive selects; halt and stall fall to hold.
  assign sel_rst   = reset;
  assign sel_init  = ~reset & (state == ST_INIT);
  assign sel_redir = ~reset & run & redirect_valid;
  assign sel_jump  = ~reset & jump_hit;
  assign sel_inc   = ~reset & fetch_en
                   & ~halt_hit & ~jump_hit;

  always_comb begin
    next_pc = pc;
    unique case (1'b1)
      sel_rst:   next_pc = '0;
      sel_init:  next_pc = ADDR_W'(1);
      sel_redir: next_pc = redirect_addr;
      sel_jump:  next_pc = jump_target(imem_rdata);
      sel_inc:   next_pc = pc + ADDR_W'(1);
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC, one-cycle ROM fetch, halt.
// IFETCH_JUMP_PREDECODE_EN enables fetch-side jumps.
module ifetch_unit
  import cpu10_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               instr_pd_jump,
  output logic               halted
);

  state_t             state;
  state_t             state_nx;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  next_pc;
  logic               fetch_en;
  logic               halt_hit;
  logic               jump_hit;
  logic               pd_q;

  ifetch_next_pc u_next_pc (
    .reset          (reset),
    .state          (state),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .pc             (pc),
    .imem_rdata     (imem_rdata),
    .fetch_en       (fetch_en),
    .halt_hit       (halt_hit),
    .jump_hit       (jump_hit),
    .next_pc        (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_INIT: state_nx = ST_RUN;
      ST_RUN:  if (halt_hit) state_nx = ST_HALT;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_INIT;
    endcase
  end

  always_comb begin
    imem_addr = pc;
    halted    = state == ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      pd_q        <= 1'b0;
    end else begin
      pc <= next_pc;
      if (state == ST_RUN && redirect_valid) begin
        instr_valid <= 1'b0;
        pd_q        <= 1'b0;
      end else if (fetch_en) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pd_q        <= jump_hit;
      end else if (state == ST_HALT) begin
        instr_valid <= 1'b0;
        pd_q        <= 1'b0;
      end
    end
  end

  assign instr_pd_jump = pd_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a behavioural ROM.
// Expectations follow IFETCH_JUMP_PREDECODE_EN.
module tb_ifetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] imem_addr;
  logic [9:0] imem_rdata;
  logic       stall;
  logic       redirect_valid;
  logic [9:0] redirect_addr;
  logic [9:0] instr;
  logic [9:0] instr_pc;
  logic       instr_valid;
  logic       instr_pd_jump;
  logic       halted;

  logic [9:0] rom [1024];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  ifetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_pd_jump  (instr_pd_jump),
    .halted         (halted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = i[9:0];
      rom[i] = {4'b0001, w[5:0]};
    end
    rom[7]  = 10'b1000001001;
    rom[40] = 10'b0010000010;

    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;

    tick();
    tick();
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_pd", instr_pd_jump, 0);
    chk("rst_halt", halted, 0);

    reset = 1'b0;
    chk("init_addr", imem_addr, 0);
    chk("init_valid", instr_valid, 0);
    tick();
    chk("run_addr1", imem_addr, 1);
    chk("run_valid1", instr_valid, 0);
    tick();
    chk("run_addr2", imem_addr, 2);
    chk("run_ipc1", instr_pc, 1);
    chk("run_instr1", instr, 10'h041);
    chk("run_valid2", instr_valid, 1);
    tick();
    chk("run_addr3", imem_addr, 3);
    chk("run_ipc2", instr_pc, 2);

    for (int n = 0; n < 20 && imem_addr != 10'd7; n++)
      tick();
    chk("reach7", imem_addr, 7);
    tick();
    chk("jmp_instr", instr, 10'b1000001001);
    chk("jmp_ipc", instr_pc, 7);
    chk("jmp_valid", instr_valid, 1);
`ifdef IFETCH_JUMP_PREDECODE_EN
    chk("jmp_addr", imem_addr, 9);
    chk("jmp_pd", instr_pd_jump, 1);
`else
    chk("jmp_addr", imem_addr, 8);
    chk("jmp_pd", instr_pd_jump, 0);
`endif

    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 10'd3;
    tick();
    chk("rs_addr", imem_addr, 3);
    chk("rs_valid", instr_valid, 0);
    stall = 1'b0;
    redirect_valid = 1'b0;
    tick();
    chk("rs_ipc", instr_pc, 3);
    chk("rs_instr", instr, 10'h043);
    chk("rs_valid2", instr_valid, 1);
    chk("rs_addr2", imem_addr, 4);

    stall = 1'b1;
    tick();
    chk("st_addr", imem_addr, 4);
    chk("st_ipc", instr_pc, 3);
    chk("st_valid", instr_valid, 1);
    stall = 1'b0;

    redirect_valid = 1'b1;
    redirect_addr = 10'd1023;
    tick();
    chk("wr_addr", imem_addr, 1023);
    chk("wr_valid", instr_valid, 0);
    redirect_valid = 1'b0;
    tick();
    chk("wr_addr2", imem_addr, 0);
    chk("wr_ipc", instr_pc, 1023);
    chk("wr_instr", instr, 10'h07F);
    chk("wr_valid2", instr_valid, 1);

    redirect_valid = 1'b1;
    redirect_addr = 10'd7;
    tick();
    chk("pri_addr7", imem_addr, 7);
    redirect_addr = 10'd20;
    tick();
    chk("pri_addr", imem_addr, 20);
    chk("pri_valid", instr_valid, 0);
    chk("pri_pd", instr_pd_jump, 0);

    redirect_addr = 10'd40;
    tick();
    chk("h_addr", imem_addr, 40);
    redirect_valid = 1'b0;
    tick();
    chk("h_instr", instr, 10'b0010000010);
    chk("h_valid", instr_valid, 1);
    chk("h_ipc", instr_pc, 40);
    chk("h_addr2", imem_addr, 40);
    chk("h_halted", halted, 1);
    redirect_valid = 1'b1;
    redirect_addr = 10'd5;
    stall = 1'b1;
    tick();
    chk("h_valid2", instr_valid, 0);
    chk("h_addr3", imem_addr, 40);
    chk("h_halted2", halted, 1);
    tick();
    chk("h_addr4", imem_addr, 40);
    chk("h_valid3", instr_valid, 0);

    reset = 1'b1;
    tick();
    chk("mr_addr", imem_addr, 0);
    chk("mr_valid", instr_valid, 0);
    chk("mr_instr", instr, 0);
    chk("mr_ipc", instr_pc, 0);
    chk("mr_pd", instr_pd_jump, 0);
    chk("mr_halt", halted, 0);
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    chk("mr_init", imem_addr, 0);
    tick();
    chk("mr_addr1", imem_addr, 1);
    chk("mr_valid1", instr_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
